// File: rtl/ibsg_edge.sv
// Rate-codes a signed operand into a unary bitstream of length 2^BSLEN for a downstream
// horizontal register chain: clear strobe, N shifted magnitude bits, then a done pulse.
module ibsg_edge #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BSLEN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_abort,
  output logic             o_clr,
  output logic             o_en,
  output logic             o_data_sign,
  output logic             o_data_dff,
  output logic             o_done
);

  localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH - 1){1'b1}}};
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [BSLEN-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StClr, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [BSLEN-1:0] cnt_q, cnt_d;
  logic [BSLEN-1:0] q_q, q_d;
  logic             sign_q, sign_d;
  logic             rst_q;

  logic [WIDTH-1:0] mag;
  logic [BSLEN-1:0] q_in;
  logic [BSLEN-1:0] cnt_rev;

  // Magnitude with the most negative value saturated, then truncated to the top BSLEN bits
  always_comb begin
    if (!i_data[WIDTH-1]) begin
      mag = i_data;
    end else if (i_data == MinNeg) begin
      mag = MaxPos;
    end else begin
      mag = ~i_data + WIDTH'(1);
    end
    q_in = BSLEN'(mag >> (WIDTH - 1 - BSLEN));
  end

  // Bit-reversed counter spreads the q ones evenly across the stream
  always_comb begin
    cnt_rev = '0;
    for (int i = 0; i < int'(BSLEN); i++) begin
      cnt_rev[i] = cnt_q[int'(BSLEN) - 1 - i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    sign_d  = sign_q;
    unique case (state_q)
      StIdle: begin
        if (i_valid && o_ready) begin
          state_d = StClr;
          q_d     = q_in;
          sign_d  = i_data[WIDTH-1] & (|q_in);
        end
      end
      StClr: begin
        state_d = i_abort ? StIdle : StRun;
      end
      StRun: begin
        if (i_abort) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + BSLEN'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      q_q     <= '0;
      sign_q  <= 1'b0;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      sign_q  <= sign_d;
      rst_q   <= 1'b0;
    end
  end

  // Registered reset flag keeps o_ready low while reset is held, without an input path
  assign o_ready     = (state_q == StIdle) && !rst_q;
  assign o_clr       = (state_q == StClr);
  assign o_en        = (state_q == StRun);
  assign o_done      = (state_q == StDone);
  assign o_data_sign = sign_q;
  assign o_data_dff  = (state_q == StRun) && (q_q > cnt_rev);

endmodule

// File: tb/tb_ibsg_edge.sv
// Self-checking bench for ibsg_edge at WIDTH=16, BSLEN=4: hand-derived vector table,
// directed abort/reset/valid-hold sequences, and random operands against an arithmetic model.
module tb_ibsg_edge;

  localparam int W = 16;
  localparam int B = 4;
  localparam int N = 16;

  logic          clk;
  logic          rst;
  logic          i_valid;
  logic          o_ready;
  logic [W-1:0]  i_data;
  logic          i_abort;
  logic          o_clr;
  logic          o_en;
  logic          o_data_sign;
  logic          o_data_dff;
  logic          o_done;

  int total = 0;
  int bad   = 0;

  ibsg_edge #(.WIDTH(W), .BSLEN(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data     (i_data),
    .i_abort    (i_abort),
    .o_clr      (o_clr),
    .o_en       (o_en),
    .o_data_sign(o_data_sign),
    .o_data_dff (o_data_dff),
    .o_done     (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        sign;
    logic [15:0] bits;  // bit c is the expected stream bit at cnt=c
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level model: saturated |x|, divide by 2^(W-1-B), compare against reversed index
  function automatic void model(input logic [15:0] d, output logic s, output logic [15:0] bits);
    int v, m, q, r;
    v = int'(signed'(d));
    m = (v < 0) ? -v : v;
    if (m > 32767) m = 32767;
    q = m / 2048;
    s = d[15] && (q != 0);
    for (int c = 0; c < N; c++) begin
      r = 0;
      for (int b = 0; b < B; b++) if (((c >> b) & 1) == 1) r += 1 << (B - 1 - b);
      bits[c] = (q > r);
    end
  endfunction

  // abort_at: -1 none, -2 during CLR, k during RUN cycle k; rst_at: -1 none, k during RUN cycle k
  task automatic run_txn(input logic [15:0] data, input logic exp_sign, input logic [15:0] bits,
                         input int abort_at, input int rst_at, input bit hold_valid,
                         input bit abort_in_done);
    chk("idle_ready", o_ready, 1);
    i_valid = 1'b1;
    i_data  = data;
    step();
    i_valid = hold_valid;
    if (hold_valid) i_data = 16'($urandom);
    chk("clr", o_clr, 1);
    chk("clr_en", o_en, 0);
    chk("clr_ready", o_ready, 0);
    chk("clr_dff", o_data_dff, 0);
    chk("clr_sign", o_data_sign, exp_sign);
    if (abort_at == -2) begin
      i_abort = 1'b1;
      step();
      i_abort = 1'b0;
      i_valid = 1'b0;
      chk("abclr_ready", o_ready, 1);
      chk("abclr_en", o_en, 0);
      chk("abclr_done", o_done, 0);
      return;
    end
    step();
    for (int k = 0; k < N; k++) begin
      if (hold_valid) i_data = 16'($urandom);
      chk("run_en", o_en, 1);
      chk("run_clr", o_clr, 0);
      chk("run_ready", o_ready, 0);
      chk("run_bit", o_data_dff, bits[k]);
      chk("run_sign", o_data_sign, exp_sign);
      if (k == abort_at) begin
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        i_valid = 1'b0;
        chk("abort_en", o_en, 0);
        chk("abort_ready", o_ready, 1);
        chk("abort_done", o_done, 0);
        chk("abort_dff", o_data_dff, 0);
        return;
      end
      if (k == rst_at) begin
        rst = 1'b1;
        step();
        i_valid = 1'b0;
        chk("rst_outs", {o_ready, o_clr, o_en, o_data_sign, o_data_dff, o_done}, 0);
        rst = 1'b0;
        step();
        chk("rst_rel_ready", o_ready, 1);
        chk("rst_rel_done", o_done, 0);
        return;
      end
      step();
    end
    chk("done", o_done, 1);
    chk("done_en", o_en, 0);
    chk("done_dff", o_data_dff, 0);
    chk("done_sign", o_data_sign, exp_sign);
    i_abort = abort_in_done;
    step();
    i_abort = 1'b0;
    i_valid = 1'b0;
    chk("post_ready", o_ready, 1);
    chk("post_done", o_done, 0);
    chk("post_sign_hold", o_data_sign, exp_sign);
  endtask

  initial begin
    vec_t vecs[8];
    logic        s;
    logic [15:0] bits;
    logic [15:0] d;
    int          r, ab;

    vecs[0] = '{16'h4000, 1'b0, 16'h5555};
    vecs[1] = '{16'h8000, 1'b1, 16'h7FFF};
    vecs[2] = '{16'hFFFF, 1'b0, 16'h0000};
    vecs[3] = '{16'h0000, 1'b0, 16'h0000};
    vecs[4] = '{16'h7FFF, 1'b0, 16'h7FFF};
    vecs[5] = '{16'hC000, 1'b1, 16'h5555};
    vecs[6] = '{16'h0800, 1'b0, 16'h0001};
    vecs[7] = '{16'h1800, 1'b0, 16'h0111};

    rst = 1'b1; i_valid = 1'b0; i_data = '0; i_abort = 1'b0;
    step();
    step();
    chk("reset_outs", {o_ready, o_clr, o_en, o_data_sign, o_data_dff, o_done}, 0);
    i_valid = 1'b1; i_data = 16'h8000; i_abort = 1'b1;
    step();
    chk("reset_prio", {o_ready, o_clr, o_en, o_data_sign, o_data_dff, o_done}, 0);
    rst = 1'b0; i_valid = 1'b0; i_abort = 1'b0;
    step();
    chk("reset_rel_ready", o_ready, 1);
    chk("reset_rel_clr", o_clr, 0);
    i_abort = 1'b1;  // abort in IDLE is ignored
    step();
    i_abort = 1'b0;
    chk("idle_abort_ready", o_ready, 1);

    for (int i = 0; i < 8; i++) run_txn(vecs[i].data, vecs[i].sign, vecs[i].bits, -1, -1, 0, 0);

    run_txn(16'h4000, 1'b0, 16'h5555, 4, -1, 0, 0);
    run_txn(16'h8000, 1'b1, 16'h7FFF, -1, -1, 0, 1);
    run_txn(16'h8000, 1'b1, 16'h7FFF, -1, -1, 1, 0);
    run_txn(16'h4000, 1'b0, 16'h5555, -2, -1, 0, 0);
    run_txn(16'h8000, 1'b1, 16'h7FFF, -1, 7, 0, 0);
    chk("post_rst_sign", o_data_sign, 0);
    run_txn(16'hC000, 1'b1, 16'h5555, 15, -1, 0, 0);

    for (int i = 0; i < 60; i++) begin
      d = 16'($urandom);
      model(d, s, bits);
      r  = int'($urandom_range(0, 5));
      ab = (r == 0) ? -2 : (r == 1) ? int'($urandom_range(0, N - 1)) : -1;
      run_txn(d, s, bits, ab, -1, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ibsg_edge.md
IBSG_EDGE -- requirements
Module: ibsg_edge

Interface
REQ-001 SHALL have parameter WIDTH, default 16: input data width, two's complement.
REQ-002 SHALL have parameter BSLEN, default 8: log2 of bitstream length N=2^BSLEN; legal range 1..WIDTH-1.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_valid  input  1  i_data is valid this cycle.
REQ-006 SHALL have port o_ready  output  1  the block accepts i_data this cycle.
REQ-007 SHALL have port i_data  input  WIDTH  signed operand to be rate-coded.
REQ-008 SHALL have port i_abort  input  1  terminates an in-progress stream.
REQ-009 SHALL have port o_clr  output  1  clear strobe to the downstream horizontal register chain.
REQ-010 SHALL have port o_en  output  1  shift enable to the downstream chain; o_data_dff is valid when o_en is high.
REQ-011 SHALL have port o_data_sign  output  1  sign of the captured operand.
REQ-012 SHALL have port o_data_dff  output  1  unary rate-coded magnitude bit.
REQ-013 SHALL have port o_done  output  1  one-cycle pulse marking stream completion.

Function
REQ-014 SHALL implement a four-state FSM: IDLE, CLR, RUN, DONE; all outputs are registered or decoded from registered state only, with no combinational input-to-output path.
REQ-015 SHALL drive o_ready=1 only in IDLE; a handshake occurs when i_valid and o_ready are both 1; i_valid outside IDLE is ignored.
REQ-016 On handshake, SHALL capture the magnitude as |i_data|, saturating the most negative value to 2^(WIDTH-1)-1.
REQ-017 SHALL form the quantized level q from magnitude bits [WIDTH-2 : WIDTH-1-BSLEN], using truncation.
REQ-018 SHALL capture sign = i_data[WIDTH-1] AND (q != 0), so a zero level always carries a positive sign.
REQ-019 IDLE -> CLR on handshake; CLR lasts exactly 1 cycle with o_clr=1 and o_en=0.
REQ-020 CLR -> RUN; RUN lasts exactly N cycles with o_en=1, and a BSLEN-bit counter cnt runs 0..N-1.
REQ-021 In RUN, SHALL drive o_data_dff = (q > bitreverse(cnt)), so exactly q ones are emitted per stream.
REQ-022 In CLR, RUN and DONE, SHALL hold o_data_sign at the captured sign; in IDLE, o_data_sign holds its last value.
REQ-023 RUN with cnt=N-1 -> DONE; DONE lasts 1 cycle with o_done=1, then -> IDLE.
REQ-024 Latency: handshake at cycle t gives o_clr at t+1, bits at t+2..t+1+N, o_done at t+2+N and o_ready at t+3+N.
REQ-025 When o_en=0, SHALL drive o_data_dff=0.
REQ-026 i_abort in CLR or RUN SHALL force IDLE on the next edge with o_en=0; o_done is not asserted and cnt resets to 0.
REQ-027 i_abort in IDLE or DONE SHALL have no effect; i_abort takes priority over cnt wrap-around in the same cycle.
REQ-028 q=0 SHALL still run the full N cycles with all-zero bits; q=N-1 SHALL give a 0 only at cnt=N-1.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, cnt=0 and captured q/sign=0; takes priority over handshake and i_abort.
REQ-030 Reset values: o_ready=0 while rst=1 and 1 on the first cycle after release; o_clr, o_en, o_data_sign, o_data_dff, o_done all 0.
REQ-031 Reset asserted mid-RUN SHALL drop o_en on the next edge; no o_done is produced.

Verification (WIDTH=16, BSLEN=4, N=16)
REQ-032 i_data=0x4000 handshake at t -> o_clr at t+1; bits 1010101010101010 at t+2..t+17; o_data_sign=0; o_done at t+18.
REQ-033 i_data=0x8000 -> sign=1, q=15; 15 ones, with a 0 only in the last bit (cnt=15).
REQ-034 i_data=0xFFFF -> q=0, sign=0; 16 zero bits; o_done still pulses at t+18.
REQ-035 i_abort at the 5th RUN cycle -> o_en=0 and o_ready=1 on the next cycle; no o_done; a new handshake restarts with o_clr.
REQ-036 i_valid held high throughout RUN with changing i_data -> no effect; the output stream matches the first operand only.
REQ-037 rst pulsed at the 8th RUN cycle -> all outputs 0 on the next cycle; o_ready=1 on the cycle after rst is released.
